// File: rtl/controlador_ascensor_pkg.sv
// -----------------------------------------------------------------------------
// controlador_ascensor_pkg
// Shared definitions for the SCAN elevator controller: default floor count,
// FSM state encodings, travel direction and a small constant helper.
// -----------------------------------------------------------------------------
package controlador_ascensor_pkg;

    localparam int N_PISOS_DEF = 10;

    typedef enum logic [1:0] {
        ST_REPOSO   = 2'd0,
        ST_SUBIENDO = 2'd1,
        ST_BAJANDO  = 2'd2,
        ST_PUERTA   = 2'd3
    } estado_t;

    typedef enum logic {
        DIR_SUBIR = 1'b0,
        DIR_BAJAR = 1'b1
    } dir_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controlador_ascensor_temporizador.sv
// -----------------------------------------------------------------------------
// temporizador_ascensor
// Loadable down-counter shared by the travel and door phases.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears the count)
//   carga       - load 'valor' this cycle (has priority over habilita)
//   habilita    - decrement by one; holds at zero
//   valor       - load value
//   cero        - count is zero
// -----------------------------------------------------------------------------
module temporizador_ascensor #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic         habilita,
    input  logic [W-1:0] valor,
    output logic         cero
);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (reset)
            cuenta <= '0;
        else if (carga)
            cuenta <= valor;
        else if (habilita && cuenta != '0)
            cuenta <= cuenta - W'(1);
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/controlador_ascensor.sv
// -----------------------------------------------------------------------------
// controlador_ascensor
// SCAN elevator scheduler over N_PISOS floors. Consumes the pending-request
// vector, drives motor/door as Moore decodes of the FSM state, tracks the
// current floor and emits a one-cycle one-hot 'atendido' mask that the
// upstream logic uses to clear the served request.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   solicitudes     - pending requests, bit i = floor i requested
//   piso_actual     - current floor index
//   motor_subir     - motor driving up   (state SUBIENDO)
//   motor_bajar     - motor driving down (state BAJANDO)
//   puerta_abierta  - door open          (state PUERTA)
//   atendido        - one-hot pulse for the floor just served
// -----------------------------------------------------------------------------
module controlador_ascensor
    import controlador_ascensor_pkg::*;
#(
    parameter int N_PISOS  = N_PISOS_DEF,
    parameter int T_VIAJE  = 4,
    parameter int T_PUERTA = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PISOS-1:0]         solicitudes,
    output logic [$clog2(N_PISOS)-1:0] piso_actual,
    output logic                       motor_subir,
    output logic                       motor_bajar,
    output logic                       puerta_abierta,
    output logic [N_PISOS-1:0]         atendido
);

    localparam int PW = $clog2(N_PISOS);
    localparam int TW = $clog2(max_int(T_VIAJE, T_PUERTA)) + 1;

    estado_t             estado, estado_sig;
    dir_t                dir, dir_sig;
    logic [PW-1:0]       piso_sig;
    logic [N_PISOS-1:0]  atendido_sig;
    logic                t_carga, t_hab, t_cero;
    logic [TW-1:0]       t_valor;
    logic                aqui, arriba, abajo, ya_atendido;

    function automatic logic hay_arriba(input logic [N_PISOS-1:0] v, input logic [PW-1:0] p);
        hay_arriba = 1'b0;
        for (int i = 0; i < N_PISOS; i++)
            if (i > int'(p) && v[i]) hay_arriba = 1'b1;
    endfunction

    function automatic logic hay_abajo(input logic [N_PISOS-1:0] v, input logic [PW-1:0] p);
        hay_abajo = 1'b0;
        for (int i = 0; i < N_PISOS; i++)
            if (i < int'(p) && v[i]) hay_abajo = 1'b1;
    endfunction

    function automatic logic en_piso(input logic [N_PISOS-1:0] v, input logic [PW-1:0] p);
        en_piso = 1'b0;
        for (int i = 0; i < N_PISOS; i++)
            if (i == int'(p) && v[i]) en_piso = 1'b1;
    endfunction

    function automatic logic [N_PISOS-1:0] onehot(input logic [PW-1:0] p);
        onehot = '0;
        for (int i = 0; i < N_PISOS; i++)
            if (i == int'(p)) onehot[i] = 1'b1;
    endfunction

    assign aqui        = en_piso(solicitudes, piso_actual);
    assign arriba      = hay_arriba(solicitudes, piso_actual);
    assign abajo       = hay_abajo(solicitudes, piso_actual);
    // The request being cleared this very cycle is still visible upstream;
    // it must not count as a fresh press while the door is open.
    assign ya_atendido = en_piso(atendido, piso_actual);

    temporizador_ascensor #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .carga    (t_carga),
        .habilita (t_hab),
        .valor    (t_valor),
        .cero     (t_cero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= ST_REPOSO;
            dir         <= DIR_SUBIR;
            piso_actual <= '0;
            atendido    <= '0;
        end else begin
            estado      <= estado_sig;
            dir         <= dir_sig;
            piso_actual <= piso_sig;
            atendido    <= atendido_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        dir_sig      = dir;
        piso_sig     = piso_actual;
        atendido_sig = '0;
        t_carga      = 1'b0;
        t_hab        = 1'b0;
        t_valor      = '0;
        case (estado)
            ST_REPOSO: begin
                if (aqui) begin
                    estado_sig   = ST_PUERTA;
                    atendido_sig = onehot(piso_actual);
                    t_carga      = 1'b1;
                    t_valor      = TW'(T_PUERTA - 1);
                end else if (dir == DIR_SUBIR) begin
                    if (arriba) begin
                        estado_sig = ST_SUBIENDO;
                    end else if (abajo) begin
                        estado_sig = ST_BAJANDO;
                        dir_sig    = DIR_BAJAR;
                    end
                end else begin
                    if (abajo) begin
                        estado_sig = ST_BAJANDO;
                    end else if (arriba) begin
                        estado_sig = ST_SUBIENDO;
                        dir_sig    = DIR_SUBIR;
                    end
                end
                if (!aqui && (arriba || abajo)) begin
                    t_carga = 1'b1;
                    t_valor = TW'(T_VIAJE - 1);
                end
            end
            ST_SUBIENDO: begin
                if (t_cero) begin
                    piso_sig   = piso_actual + PW'(1);
                    estado_sig = ST_REPOSO;
                end else begin
                    t_hab = 1'b1;
                end
            end
            ST_BAJANDO: begin
                if (t_cero) begin
                    piso_sig   = piso_actual - PW'(1);
                    estado_sig = ST_REPOSO;
                end else begin
                    t_hab = 1'b1;
                end
            end
            ST_PUERTA: begin
                if (aqui && !ya_atendido) begin
                    atendido_sig = onehot(piso_actual);
                    t_carga      = 1'b1;
                    t_valor      = TW'(T_PUERTA - 1);
                end else if (t_cero) begin
                    estado_sig = ST_REPOSO;
                end else begin
                    t_hab = 1'b1;
                end
            end
            default: estado_sig = ST_REPOSO;
        endcase
    end

    assign motor_subir    = (estado == ST_SUBIENDO);
    assign motor_bajar    = (estado == ST_BAJANDO);
    assign puerta_abierta = (estado == ST_PUERTA);

endmodule
